// File: rtl/dmi_resp_fifo.sv
// DMI response FIFO on tck_i: circular buffer with registered or fall-through output, flush and fill level.
// Optional peak-occupancy monitor hwm_o is enabled by defining DMI_RESP_FIFO_HWM_EN.
module dmi_resp_fifo #(
    parameter int unsigned WIDTH        = 34,
    parameter int unsigned DEPTH        = 4,
    parameter bit          FALL_THROUGH = 1'b0
) (
    input  logic                       tck_i,
    input  logic                       trst_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           dmi_resp_i,
    input  logic                       dmi_resp_valid_i,
    output logic                       dmi_resp_ready_o,
    output logic [WIDTH-1:0]           dmi_resp_o,
    output logic                       dmi_resp_valid_o,
    input  logic                       dmi_resp_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
`ifdef DMI_RESP_FIFO_HWM_EN
   ,output logic [$clog2(DEPTH+1)-1:0] hwm_o
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic empty, full;
    logic push, pop, bypass;
    logic wr_en, rd_en;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == CW'(DEPTH));

        dmi_resp_ready_o = ~flush_i & (~full | dmi_resp_ready_i);

        if (FALL_THROUGH && empty) begin
            dmi_resp_valid_o = dmi_resp_valid_i & ~flush_i;
            dmi_resp_o       = dmi_resp_i;
        end else begin
            dmi_resp_valid_o = ~empty;
            dmi_resp_o       = mem_q[rd_ptr_q];
        end

        push   = dmi_resp_valid_i & dmi_resp_ready_o & ~flush_i;
        pop    = dmi_resp_valid_o & dmi_resp_ready_i & ~flush_i;
        // A beat popped while empty never touches storage.
        bypass = FALL_THROUGH & empty & pop;
        wr_en  = push & ~bypass;
        rd_en  = pop & ~bypass;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
            unique case ({wr_en, rd_en})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge tck_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= dmi_resp_i;
    end

    assign count_o = count_q;

`ifdef DMI_RESP_FIFO_HWM_EN
    logic [CW-1:0] hwm_q, hwm_d;

    always_comb begin
        hwm_d = hwm_q;
        if (flush_i)              hwm_d = '0;
        else if (count_d > hwm_q) hwm_d = count_d;
    end

    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) hwm_q <= '0;
        else        hwm_q <= hwm_d;
    end

    assign hwm_o = hwm_q;
`endif

endmodule

// File: tb/tb_dmi_resp_fifo.sv
// Directed self-checking bench for dmi_resp_fifo: DEPTH=4 registered, DEPTH=3 registered, DEPTH=4 fall-through.
// Define DMI_RESP_FIFO_HWM_EN to also check the peak-occupancy monitor.
module tb_dmi_resp_fifo;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance a: DEPTH=4 registered
    logic        a_fl, a_vi, a_ri, a_ro, a_vo;
    logic [33:0] a_din, a_dout;
    logic [2:0]  a_cnt, a_hwm;
    // Instance b: DEPTH=3 registered
    logic        b_fl, b_vi, b_ri, b_ro, b_vo;
    logic [33:0] b_din, b_dout;
    logic [1:0]  b_cnt, b_hwm;
    // Instance c: DEPTH=4 fall-through
    logic        c_fl, c_vi, c_ri, c_ro, c_vo;
    logic [33:0] c_din, c_dout;
    logic [2:0]  c_cnt, c_hwm;

    dmi_resp_fifo #(.WIDTH(34), .DEPTH(4), .FALL_THROUGH(1'b0)) u_a (
        .tck_i(clk), .trst_i(rst), .flush_i(a_fl),
        .dmi_resp_i(a_din), .dmi_resp_valid_i(a_vi), .dmi_resp_ready_o(a_ro),
        .dmi_resp_o(a_dout), .dmi_resp_valid_o(a_vo), .dmi_resp_ready_i(a_ri),
        .count_o(a_cnt)
`ifdef DMI_RESP_FIFO_HWM_EN
       ,.hwm_o(a_hwm)
`endif
    );

    dmi_resp_fifo #(.WIDTH(34), .DEPTH(3), .FALL_THROUGH(1'b0)) u_b (
        .tck_i(clk), .trst_i(rst), .flush_i(b_fl),
        .dmi_resp_i(b_din), .dmi_resp_valid_i(b_vi), .dmi_resp_ready_o(b_ro),
        .dmi_resp_o(b_dout), .dmi_resp_valid_o(b_vo), .dmi_resp_ready_i(b_ri),
        .count_o(b_cnt)
`ifdef DMI_RESP_FIFO_HWM_EN
       ,.hwm_o(b_hwm)
`endif
    );

    dmi_resp_fifo #(.WIDTH(34), .DEPTH(4), .FALL_THROUGH(1'b1)) u_c (
        .tck_i(clk), .trst_i(rst), .flush_i(c_fl),
        .dmi_resp_i(c_din), .dmi_resp_valid_i(c_vi), .dmi_resp_ready_o(c_ro),
        .dmi_resp_o(c_dout), .dmi_resp_valid_o(c_vo), .dmi_resp_ready_i(c_ri),
        .count_o(c_cnt)
`ifdef DMI_RESP_FIFO_HWM_EN
       ,.hwm_o(c_hwm)
`endif
    );

`ifndef DMI_RESP_FIFO_HWM_EN
    assign a_hwm = '0;
    assign b_hwm = '0;
    assign c_hwm = '0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a_fl = 0; a_vi = 0; a_ri = 0; a_din = '0;
        b_fl = 0; b_vi = 0; b_ri = 0; b_din = '0;
        c_fl = 0; c_vi = 0; c_ri = 0; c_din = '0;
        #3;
        chk("rst_a_cnt", 64'(a_cnt), 64'd0);
        chk("rst_a_vo",  64'(a_vo),  64'd0);
        chk("rst_a_ro",  64'(a_ro),  64'd1);
        chk("rst_b_cnt", 64'(b_cnt), 64'd0);
        chk("rst_c_cnt", 64'(c_cnt), 64'd0);
`ifdef DMI_RESP_FIFO_HWM_EN
        chk("rst_a_hwm", 64'(a_hwm), 64'd0);
`endif
        #4 rst = 1'b0;
        tick();

        // Fill DEPTH=4 with downstream stalled, then drain in order
        a_ri = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_vi = 1'b1; a_din = 34'h100 + 34'(i);
            tick();
        end
        a_vi = 1'b0;
        #1;
        chk("full_a_cnt", 64'(a_cnt), 64'd4);
        chk("full_a_ro",  64'(a_ro),  64'd0);
        a_ri = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_a_vo",   64'(a_vo),   64'd1);
            chk("drain_a_data", 64'(a_dout), 64'h100 + 64'(i));
            tick();
        end
        chk("drain_a_cnt", 64'(a_cnt), 64'd0);
        chk("drain_a_vo0", 64'(a_vo),  64'd0);
        a_ri = 1'b0;

        // DEPTH=3 full with simultaneous push/pop across pointer wrap
        for (int i = 0; i < 3; i++) begin
            b_vi = 1'b1; b_din = 34'h200 + 34'(i);
            tick();
        end
        chk("full_b_cnt", 64'(b_cnt), 64'd3);
        b_ri = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b_vi = 1'b1; b_din = 34'h300 + 34'(i);
            #1;
            chk("pp_b_ro",   64'(b_ro), 64'd1);
            chk("pp_b_vo",   64'(b_vo), 64'd1);
            chk("pp_b_data", 64'(b_dout), (i < 3) ? 64'h200 + 64'(i) : 64'h300 + 64'(i - 3));
            tick();
            chk("pp_b_cnt", 64'(b_cnt), 64'd3);
        end
        b_vi = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("tail_b_data", 64'(b_dout), 64'h302 + 64'(i));
            tick();
        end
        chk("tail_b_cnt", 64'(b_cnt), 64'd0);
        b_ri = 1'b0;

        // Fall-through bypass when empty
        c_vi = 1'b1; c_din = 34'h3_DEADBEEF; c_ri = 1'b1;
        #1;
        chk("ft_vo",   64'(c_vo),   64'd1);
        chk("ft_data", 64'(c_dout), 64'h3_DEADBEEF);
        chk("ft_cnt",  64'(c_cnt),  64'd0);
        tick();
        chk("ft_cnt_after", 64'(c_cnt), 64'd0);
        c_ri = 1'b0; c_din = 34'h1_2345678;
        #1;
        chk("ft_stall_data", 64'(c_dout), 64'h1_2345678);
        tick();
        c_din = 34'h0_00000AAA;
        #1;
        chk("ft_stored_cnt",  64'(c_cnt),  64'd1);
        chk("ft_stored_data", 64'(c_dout), 64'h1_2345678);
        c_vi = 1'b0; c_ri = 1'b1;
        tick();
        c_ri = 1'b0;
        #1;
        chk("ft_empty_cnt", 64'(c_cnt), 64'd0);
        chk("ft_empty_vo",  64'(c_vo),  64'd0);

        // Flush with count=2 while push and pop are requested
        a_vi = 1'b1; a_din = 34'h0AB; tick();
        a_din = 34'h0CD; tick();
        chk("pre_fl_cnt", 64'(a_cnt), 64'd2);
        a_fl = 1'b1; a_din = 34'h0EF; a_ri = 1'b1;
        #1;
        chk("fl_ro", 64'(a_ro), 64'd0);
        tick();
        a_fl = 1'b0; a_vi = 1'b0; a_ri = 1'b0;
        #1;
        chk("fl_cnt", 64'(a_cnt), 64'd0);
        chk("fl_vo",  64'(a_vo),  64'd0);
`ifdef DMI_RESP_FIFO_HWM_EN
        chk("fl_hwm", 64'(a_hwm), 64'd0);
`endif
        a_vi = 1'b1; a_din = 34'h0F0; tick();
        a_vi = 1'b0;
        #1;
        chk("postfl_data", 64'(a_dout), 64'h0F0);
        chk("postfl_cnt",  64'(a_cnt),  64'd1);
        a_ri = 1'b1; tick(); a_ri = 1'b0;
        chk("postfl_cnt0", 64'(a_cnt), 64'd0);

        // Asynchronous reset mid-burst, between edges
        a_vi = 1'b1; a_din = 34'h111; tick();
        a_din = 34'h112; tick();
        a_din = 34'h113;
        #3 rst = 1'b1;
        #1;
        chk("ar_cnt", 64'(a_cnt), 64'd0);
        chk("ar_vo",  64'(a_vo),  64'd0);
        chk("ar_ro",  64'(a_ro),  64'd1);
`ifdef DMI_RESP_FIFO_HWM_EN
        chk("ar_hwm", 64'(a_hwm), 64'd0);
`endif
        #1 rst = 1'b0;
        a_din = 34'h120;
        tick();
        a_vi = 1'b0;
        #1;
        chk("ar_first_cnt",  64'(a_cnt),  64'd1);
        chk("ar_first_data", 64'(a_dout), 64'h120);
        a_ri = 1'b1; tick(); a_ri = 1'b0;
        chk("ar_drain_cnt", 64'(a_cnt), 64'd0);

`ifdef DMI_RESP_FIFO_HWM_EN
        // Peak occupancy survives drain and refill
        a_vi = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_din = 34'h140 + 34'(i); tick();
        end
        a_vi = 1'b0;
        chk("hwm_fill", 64'(a_hwm), 64'd3);
        a_ri = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        a_ri = 1'b0;
        chk("hwm_drain_cnt", 64'(a_cnt), 64'd0);
        chk("hwm_drain",     64'(a_hwm), 64'd3);
        a_vi = 1'b1; a_din = 34'h150; tick();
        a_vi = 1'b0;
        chk("hwm_refill_cnt", 64'(a_cnt), 64'd1);
        chk("hwm_refill",     64'(a_hwm), 64'd3);
        tick();
        chk("hwm_refill2",    64'(a_hwm), 64'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
